// File: rtl/core_debug_responder.sv
// Debug command responder sitting between an external debugger and a CPU core.
// It accepts one command at a time, drives the core halt/step/register
// handshakes, and returns a single-cycle response strobe with error and data.
//
// Ports:
//   iCLOCK, inRESET            clock (rising edge), async active-low reset
//   iDEBUG_CMD_*               command request from debugger (REQ/COMMAND/TARGET/DATA)
//   oDEBUG_CMD_BUSY            high whenever a command is in flight
//   oDEBUG_CMD_VALID/ERROR/DATA one-cycle response to the debugger
//   oCORE_HALT_REQ/INT_EN      core run control levels
//   oCORE_STEP/iCORE_STEP_DONE single-step handshake
//   iCORE_HALTED               core pipeline drained and stopped
//   oREG_*/iREG_RD_*           core register file access
module core_debug_responder (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iDEBUG_CMD_REQ,
    output logic        oDEBUG_CMD_BUSY,
    input  logic [3:0]  iDEBUG_CMD_COMMAND,
    input  logic [7:0]  iDEBUG_CMD_TARGET,
    input  logic [31:0] iDEBUG_CMD_DATA,
    output logic        oDEBUG_CMD_VALID,
    output logic        oDEBUG_CMD_ERROR,
    output logic [31:0] oDEBUG_CMD_DATA,
    output logic        oCORE_HALT_REQ,
    input  logic        iCORE_HALTED,
    output logic        oCORE_INT_EN,
    output logic        oCORE_STEP,
    input  logic        iCORE_STEP_DONE,
    output logic        oREG_RD_REQ,
    output logic        oREG_WR_EN,
    output logic [7:0]  oREG_TARGET,
    output logic [31:0] oREG_WR_DATA,
    input  logic        iREG_RD_VALID,
    input  logic [31:0] iREG_RD_DATA
);

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned TGT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CMD_W-1:0] CMD_READ_REG   = CMD_W'(4'h0);
    localparam logic [CMD_W-1:0] CMD_WRITE_REG  = CMD_W'(4'h1);
    localparam logic [CMD_W-1:0] CMD_GO         = CMD_W'(4'h8);
    localparam logic [CMD_W-1:0] CMD_INTGO      = CMD_W'(4'h9);
    localparam logic [CMD_W-1:0] CMD_SINGLESTEP = CMD_W'(4'hA);
    localparam logic [CMD_W-1:0] CMD_STOP       = CMD_W'(4'hF);

    localparam logic [TGT_W-1:0] TGT_READ_ONLY = TGT_W'(8'd64);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(8'hFF);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_WAIT = 3'd1,
        S_RD_WAIT   = 3'd2,
        S_WR        = 3'd3,
        S_STEP_WAIT = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                busy_q,     busy_d;
    logic                valid_q,    valid_d;
    logic                error_q,    error_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                halt_req_q, halt_req_d;
    logic                int_en_q,   int_en_d;
    logic                step_q,     step_d;
    logic                rd_req_q,   rd_req_d;
    logic                wr_en_q,    wr_en_d;
    logic [TGT_W-1:0]    target_q,   target_d;
    logic [DATA_W-1:0]   wr_data_q,  wr_data_d;

    // Register map: GPRs 0-31, system regs 64-78, debug regs 128-132.
    function automatic logic target_ok(input logic [TGT_W-1:0] t);
        return (t <= TGT_W'(8'd31))
            || ((t >= TGT_W'(8'd64))  && (t <= TGT_W'(8'd78)))
            || ((t >= TGT_W'(8'd128)) && (t <= TGT_W'(8'd132)));
    endfunction

    // State and registered outputs
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            rsp_data_q <= '0;
            halt_req_q <= 1'b0;
            int_en_q   <= 1'b0;
            step_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            target_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            rsp_data_q <= rsp_data_d;
            halt_req_q <= halt_req_d;
            int_en_q   <= int_en_d;
            step_q     <= step_d;
            rd_req_q   <= rd_req_d;
            wr_en_q    <= wr_en_d;
            target_q   <= target_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state and next-output logic; any transition into S_RESP also
    // loads the response strobe so VALID lines up with the RESP cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        rsp_data_d = '0;
        halt_req_d = halt_req_q;
        int_en_d   = int_en_q;
        step_d     = 1'b0;
        rd_req_d   = 1'b0;
        wr_en_d    = 1'b0;
        target_d   = target_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (iDEBUG_CMD_REQ) begin
                    target_d  = iDEBUG_CMD_TARGET;
                    wr_data_d = iDEBUG_CMD_DATA;
                    cnt_d     = '0;
                    case (iDEBUG_CMD_COMMAND)
                        CMD_READ_REG: begin
                            if (!iCORE_HALTED || !target_ok(iDEBUG_CMD_TARGET)) begin
                                state_d = S_RESP;
                                valid_d = 1'b1;
                                error_d = 1'b1;
                            end else begin
                                rd_req_d = 1'b1;
                                state_d  = S_RD_WAIT;
                            end
                        end
                        CMD_WRITE_REG: begin
                            if (!iCORE_HALTED || !target_ok(iDEBUG_CMD_TARGET)
                                || (iDEBUG_CMD_TARGET == TGT_READ_ONLY)) begin
                                state_d = S_RESP;
                                valid_d = 1'b1;
                                error_d = 1'b1;
                            end else begin
                                wr_en_d = 1'b1;
                                state_d = S_WR;
                            end
                        end
                        CMD_GO, CMD_INTGO: begin
                            // Resuming a running core is harmless and reported as success.
                            halt_req_d = 1'b0;
                            int_en_d   = (iDEBUG_CMD_COMMAND == CMD_INTGO);
                            state_d    = S_RESP;
                            valid_d    = 1'b1;
                        end
                        CMD_SINGLESTEP: begin
                            if (!iCORE_HALTED) begin
                                state_d = S_RESP;
                                valid_d = 1'b1;
                                error_d = 1'b1;
                            end else begin
                                step_d  = 1'b1;
                                state_d = S_STEP_WAIT;
                            end
                        end
                        CMD_STOP: begin
                            halt_req_d = 1'b1;
                            if (iCORE_HALTED) begin
                                state_d = S_RESP;
                                valid_d = 1'b1;
                            end else begin
                                state_d = S_HALT_WAIT;
                            end
                        end
                        default: begin
                            state_d = S_RESP;
                            valid_d = 1'b1;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end

            // Wait states: the awaited input wins over the timeout when both
            // land on the same cycle. HALT_REQ is left untouched on timeout.
            S_HALT_WAIT: begin
                if (iCORE_HALTED) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RD_WAIT: begin
                if (iREG_RD_VALID) begin
                    state_d    = S_RESP;
                    valid_d    = 1'b1;
                    rsp_data_d = iREG_RD_DATA;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WR: begin
                state_d = S_RESP;
                valid_d = 1'b1;
            end

            S_STEP_WAIT: begin
                if (iCORE_STEP_DONE) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Busy is registered from the next state so it tracks state_q exactly.
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    assign oDEBUG_CMD_BUSY  = busy_q;
    assign oDEBUG_CMD_VALID = valid_q;
    assign oDEBUG_CMD_ERROR = error_q;
    assign oDEBUG_CMD_DATA  = rsp_data_q;
    assign oCORE_HALT_REQ   = halt_req_q;
    assign oCORE_INT_EN     = int_en_q;
    assign oCORE_STEP       = step_q;
    assign oREG_RD_REQ      = rd_req_q;
    assign oREG_WR_EN       = wr_en_q;
    assign oREG_TARGET      = target_q;
    assign oREG_WR_DATA     = wr_data_q;

endmodule
